// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetch stage feeding the control unit. Holds the program counter, fetches
//   one instruction word per req/ack transaction, latches it into the
//   instruction register and applies jump/branch redirects decided downstream.
//   One instruction in flight at a time; no prefetch.
//
// Ports
//   clock, rst_n        clock / asynchronous active-low reset
//   imem_req/addr       fetch request (held until ack) and address (= pc)
//   imem_ack/rdata      memory response, data valid with ack
//   stall               downstream hold while an instruction is presented
//   jump, branch_taken  redirect requests, sampled only when leaving DECODE
//   target              redirect address
//   pc, instr, opcode   program counter, instruction register, instr[top 4]
//   instr_valid         instr is fresh and not yet consumed
//   pc_we, ir_we        registered one-cycle update pulses
module instruction_fetch #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clock,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               jump,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  target,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic               instr_valid,
    output logic               pc_we,
    output logic               ir_we
);

    typedef enum logic [1:0] {RESET, FETCH, DECODE} state_t;

    localparam logic [ADDR_W-1:0] PC_INC = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc_nx;
    logic              ld_pc, ld_ir;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= RESET;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        ld_pc    = 1'b0;
        ld_ir    = 1'b0;
        case (state)
            RESET:  state_nx = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    ld_ir    = 1'b1;
                    state_nx = DECODE;
                end
            end
            DECODE: begin
                if (!stall) begin
                    ld_pc    = 1'b1;
                    // Both redirect sources share one target, so either one wins.
                    pc_nx    = (jump || branch_taken) ? target : pc + PC_INC;
                    state_nx = FETCH;
                end
            end
            default: state_nx = RESET;
        endcase
    end

    // Update pulses are registered so they line up with the cycle in which
    // the new pc / instr value is first visible.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            instr <= '0;
            pc_we <= 1'b0;
            ir_we <= 1'b0;
        end else begin
            pc_we <= ld_pc;
            ir_we <= ld_ir;
            if (ld_pc) pc    <= pc_nx;
            if (ld_ir) instr <= imem_rdata;
        end
    end

    // Request and valid decode straight from state so reset drops them
    // asynchronously; pc is 0 in reset, which keeps imem_addr at 0 too.
    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == DECODE);
    assign opcode      = instr[INSTR_W-1 -: 4];

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  target = '0;
    logic [7:0]  pc;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic        instr_valid;
    logic        pc_we;
    logic        ir_we;

    instruction_fetch #(.ADDR_W(8), .INSTR_W(16)) dut (
        .clock(clock), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .jump(jump), .branch_taken(branch_taken), .target(target),
        .pc(pc), .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
        .pc_we(pc_we), .ir_we(ir_we)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: memory image, program counter as a plain integer and
    // the expected results queued for the monitor.
    logic [15:0] mem [256];
    int          model_pc = 0;
    logic [15:0] exp_instr_q[$];
    int          exp_pc_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   32'(imem_req), 0);
        chk({tag, "_addr"},  32'(imem_addr), 0);
        chk({tag, "_pc"},    32'(pc), 0);
        chk({tag, "_instr"}, 32'(instr), 0);
        chk({tag, "_op"},    32'(opcode), 0);
        chk({tag, "_vld"},   32'(instr_valid), 0);
        chk({tag, "_pcwe"},  32'(pc_we), 0);
        chk({tag, "_irwe"},  32'(ir_we), 0);
    endtask

    // One complete instruction: 'waits' cycles with ack low, ack, 'stalls'
    // stalled DECODE cycles, then release with the given redirect inputs.
    // Called at a negedge where the DUT is (or is about to be) in FETCH.
    task automatic do_instr(input int waits, input int stalls,
                            input logic jmp, input logic br, input logic [7:0] tgt);
        int t = 0;
        while (!imem_req && t < 20) begin
            @(negedge clock);
            t++;
        end
        chk("req_present", 32'(imem_req), 1);
        for (int w = 0; w < waits; w++) begin
            imem_ack = 1'b0; imem_rdata = 16'($urandom);
            jump = 1'($urandom); branch_taken = 1'($urandom); target = 8'($urandom);
            stall = 1'($urandom);
            @(negedge clock);
        end
        imem_ack = 1'b1; imem_rdata = mem[model_pc];
        exp_instr_q.push_back(mem[model_pc]);
        jump = 1'($urandom); branch_taken = 1'($urandom); target = 8'($urandom);
        @(negedge clock);
        for (int s = 0; s < stalls; s++) begin
            imem_ack = 1'($urandom); imem_rdata = 16'($urandom);
            stall = 1'b1; jump = jmp; branch_taken = br; target = tgt;
            @(negedge clock);
        end
        imem_ack = 1'($urandom); imem_rdata = 16'($urandom);
        stall = 1'b0; jump = jmp; branch_taken = br; target = tgt;
        model_pc = (jmp || br) ? int'(tgt) : (model_pc + 1) % 256;
        exp_pc_q.push_back(model_pc);
        @(negedge clock);
        jump = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    endtask

    task automatic release_reset();
        imem_ack = 1'b0;
        rst_n = 1'b1;
        model_pc = 0;
        @(negedge clock);
        chk("first_req", 32'(imem_req), 1);
        chk("first_addr", 32'(imem_addr), 0);
    endtask

    // Monitor: pops the expected values whenever the DUT pulses an update and
    // checks the holding rules cycle by cycle.
    initial begin : monitor
        logic        pv, pr;
        logic [7:0]  ppc, paddr;
        logic [15:0] pinstr;
        logic [15:0] ei;
        int          ep;
        pv = 0; pr = 0; ppc = 0; paddr = 0; pinstr = 0;
        forever begin
            @(negedge clock);
            if (!rst_n) begin
                pv = 0; pr = 0;
            end else begin
                chk("we_exclusive", 32'(pc_we & ir_we), 0);
                if (ir_we) begin
                    if (exp_instr_q.size() == 0) chk("ir_we_unexpected", 1, 0);
                    else begin
                        ei = exp_instr_q.pop_front();
                        chk("instr", 32'(instr), 32'(ei));
                        chk("opcode", 32'(opcode), 32'(ei[15:12]));
                        chk("valid_after_ack", 32'(instr_valid), 1);
                    end
                end
                if (pc_we) begin
                    if (exp_pc_q.size() == 0) chk("pc_we_unexpected", 1, 0);
                    else begin
                        ep = exp_pc_q.pop_front();
                        chk("pc", 32'(pc), 32'(ep));
                        chk("next_fetch_addr", 32'(imem_addr), 32'(ep));
                        chk("next_fetch_req", 32'(imem_req), 1);
                    end
                end
                if (pr && imem_req) begin
                    chk("wait_addr_stable", 32'(imem_addr), 32'(paddr));
                    chk("wait_no_ir_we", 32'(ir_we), 0);
                end
                if (pv && instr_valid) begin
                    chk("stall_pc_hold", 32'(pc), 32'(ppc));
                    chk("stall_instr_hold", 32'(instr), 32'(pinstr));
                end
                if (imem_req) chk("req_not_valid", 32'(instr_valid), 0);
                pv = instr_valid; pr = imem_req;
                ppc = pc; paddr = imem_addr; pinstr = instr;
            end
        end
    end

    initial begin : stim
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1234;
        mem[1] = 16'h5678;

        // Reset state, including an ack driven while in reset.
        @(negedge clock);
        imem_ack = 1'b1; imem_rdata = 16'hBEEF;
        @(negedge clock);
        chk_reset_outputs("rst0");
        release_reset();

        // Sequential fetch 0,1 then up to address 4 with 3 wait states.
        do_instr(0, 0, 0, 0, 8'h00);
        do_instr(0, 0, 0, 0, 8'h00);
        do_instr(0, 0, 0, 0, 8'h00);
        do_instr(1, 0, 0, 0, 8'h00);
        do_instr(3, 0, 0, 0, 8'h00);       // pc=4
        do_instr(0, 0, 1, 0, 8'h07);       // pc=5 -> 7
        do_instr(0, 0, 1, 0, 8'h20);       // pc=7 -> 0x20
        do_instr(3, 0, 0, 0, 8'h00);       // jump toggles during FETCH: ignored
        do_instr(0, 5, 0, 1, 8'h40);       // stalled branch to 0x40
        do_instr(0, 0, 1, 1, 8'hFF);       // both redirects high
        do_instr(0, 0, 0, 0, 8'h00);       // 0xFF wraps to 0x00

        for (int n = 0; n < 200; n++)
            do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                     1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                     8'($urandom));

        // Reset mid-fetch with the ack still pending, then a late ack.
        imem_ack = 1'b0;
        @(negedge clock);
        chk("pre_reset_req", 32'(imem_req), 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_fetch");
        imem_ack = 1'b1; imem_rdata = 16'hFFFF;
        @(negedge clock);
        @(negedge clock);
        chk("late_ack_instr", 32'(instr), 0);
        release_reset();
        do_instr(0, 0, 0, 0, 8'h00);
        do_instr(1, 1, 0, 0, 8'h00);

        // Reset while presenting an instruction.
        imem_ack = 1'b1; imem_rdata = mem[model_pc];
        exp_instr_q.push_back(mem[model_pc]);
        @(negedge clock);
        imem_ack = 1'b0; stall = 1'b1;
        chk("pre_reset_valid", 32'(instr_valid), 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_decode");
        stall = 1'b0;
        @(negedge clock);
        release_reset();
        for (int n = 0; n < 20; n++)
            do_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                     1'($urandom), 1'b0, 8'($urandom));

        @(negedge clock);
        chk("instr_q_empty", 32'(exp_instr_q.size()), 0);
        chk("pc_q_empty", 32'(exp_pc_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
